// File: rtl/adc_sync_demod.sv
// adc_sync_demod
//
// Square-wave synchronous demodulator for the 12-bit ADC sample stream.
// Each modulation period is split into a positive half (mod_phase = 1) and
// a negative half (mod_phase = 0). After every phase edge a few settling
// samples are dropped, then a fixed number of samples is summed. Once both
// halves are complete, one signed error word (positive sum minus negative
// sum) goes to the servo loop.
//
// Optional build macro: ADC_SYNC_DEMOD_AVG_EN
//   defined   -> err_data is the difference arithmetically shifted right by
//                ACC_LOG2 (floor), i.e. the per-sample mean difference
//   undefined -> err_data is the raw difference
//
// Ports:
//   clk_10m_bufg     in   system clock (10 MHz)
//   rst_glb          in   asynchronous active-low reset
//   adc_data_sample  in   offset-binary ADC sample, valid with adc_ready
//   adc_ready        in   one-cycle sample strobe
//   mod_phase        in   modulation phase (asynchronous, synchronized here)
//   demod_en         in   enable; low aborts and idles the block
//   err_data         out  signed error word, held between updates
//   err_valid        out  one-cycle pulse when err_data updates
//   overrun          out  one-cycle pulse when a half ends before ACC_N samples
//   busy             out  high whenever the FSM is not in IDLE

module adc_sync_demod #(
   parameter int DATA_W   = 12,
   parameter int ACC_LOG2 = 6,
   parameter int DISCARD  = 4,
   parameter int OUT_W    = DATA_W + ACC_LOG2 + 1
) (
   input  logic              clk_10m_bufg,
   input  logic              rst_glb,
   input  logic [DATA_W-1:0] adc_data_sample,
   input  logic              adc_ready,
   input  logic              mod_phase,
   input  logic              demod_en,
   output logic [OUT_W-1:0]  err_data,
   output logic              err_valid,
   output logic              overrun,
   output logic              busy
);

   localparam int         SUM_W     = DATA_W + ACC_LOG2;
   localparam int         ACC_N     = 1 << ACC_LOG2;
   localparam logic [7:0] DISC_LAST = 8'(DISCARD - 1);
   localparam logic [7:0] ACC_LAST  = 8'(ACC_N - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_RISE = 3'd1;
   localparam logic [2:0] DISC_P    = 3'd2;
   localparam logic [2:0] ACC_P     = 3'd3;
   localparam logic [2:0] WAIT_FALL = 3'd4;
   localparam logic [2:0] DISC_N    = 3'd5;
   localparam logic [2:0] ACC_N_ST  = 3'd6;
   localparam logic [2:0] CALC      = 3'd7;

   logic [2:0]       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [SUM_W-1:0] sum_pos_q, sum_pos_d;
   logic [SUM_W-1:0] sum_neg_q, sum_neg_d;
   logic [OUT_W-1:0] err_data_q, err_data_d;
   logic             err_valid_q, err_valid_d;
   logic             overrun_q, overrun_d;
   logic             ph_s1_q, ph_s2_q, ph_s3_q;

   logic             rise, fall, smp;
   logic [SUM_W-1:0] sample_ext;
   logic [OUT_W-1:0] diff_raw;
   logic [OUT_W-1:0] calc_val;

   // Two-flop synchronizer for the asynchronous phase input, plus a third
   // flop holding the previous synchronized value for edge detection.
   always_ff @(posedge clk_10m_bufg or negedge rst_glb) begin
      if (!rst_glb) begin
         ph_s1_q <= 1'b0;
         ph_s2_q <= 1'b0;
         ph_s3_q <= 1'b0;
      end else begin
         ph_s1_q <= mod_phase;
         ph_s2_q <= ph_s1_q;
         ph_s3_q <= ph_s2_q;
      end
   end

   // A phase edge wins over a coincident strobe: that sample is never counted.
   assign rise       = ph_s2_q & ~ph_s3_q;
   assign fall       = ~ph_s2_q & ph_s3_q;
   assign smp        = adc_ready & ~(rise | fall);
   assign sample_ext = {{ACC_LOG2{1'b0}}, adc_data_sample};
   assign diff_raw   = {{(OUT_W-SUM_W){1'b0}}, sum_pos_q}
                     - {{(OUT_W-SUM_W){1'b0}}, sum_neg_q};

`ifdef ADC_SYNC_DEMOD_AVG_EN
   // Arithmetic shift floors toward minus infinity and keeps the sign.
   assign calc_val = OUT_W'($signed(diff_raw) >>> ACC_LOG2);
`else
   assign calc_val = diff_raw;
`endif

   // Next-state logic for the demodulation sequence. A disabled block is
   // forced back to IDLE from anywhere, dropping any result still pending.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_pos_d   = sum_pos_q;
      sum_neg_d   = sum_neg_q;
      err_data_d  = err_data_q;
      err_valid_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            sum_pos_d = '0;
            sum_neg_d = '0;
            if (demod_en) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (rise) begin
               state_d = DISC_P;
               cnt_d   = '0;
            end
         end
         DISC_P, ACC_P: begin
            if (fall) begin
               // Positive half cut short: throw the partial sum away.
               overrun_d = 1'b1;
               state_d   = WAIT_RISE;
               cnt_d     = '0;
               sum_pos_d = '0;
            end else if (smp) begin
               if (state_q == DISC_P) begin
                  if (cnt_q == DISC_LAST) begin
                     state_d   = ACC_P;
                     cnt_d     = '0;
                     sum_pos_d = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  sum_pos_d = sum_pos_q + sample_ext;
                  if (cnt_q == ACC_LAST) begin
                     state_d = WAIT_FALL;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
         end
         WAIT_FALL: begin
            if (fall) begin
               state_d = DISC_N;
               cnt_d   = '0;
            end
         end
         DISC_N, ACC_N_ST: begin
            if (rise) begin
               // Negative half cut short: the rise already opens a new period.
               overrun_d = 1'b1;
               state_d   = DISC_P;
               cnt_d     = '0;
               sum_neg_d = '0;
            end else if (smp) begin
               if (state_q == DISC_N) begin
                  if (cnt_q == DISC_LAST) begin
                     state_d   = ACC_N_ST;
                     cnt_d     = '0;
                     sum_neg_d = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  sum_neg_d = sum_neg_q + sample_ext;
                  if (cnt_q == ACC_LAST) begin
                     state_d = CALC;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
         end
         CALC: begin
            err_data_d  = calc_val;
            err_valid_d = 1'b1;
            cnt_d       = '0;
            // A rise landing exactly here must not be lost.
            state_d     = rise ? DISC_P : WAIT_RISE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!demod_en) begin
         state_d     = IDLE;
         cnt_d       = '0;
         sum_pos_d   = '0;
         sum_neg_d   = '0;
         err_data_d  = err_data_q;
         err_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   // State, counter, accumulator and output registers.
   always_ff @(posedge clk_10m_bufg or negedge rst_glb) begin
      if (!rst_glb) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sum_pos_q   <= '0;
         sum_neg_q   <= '0;
         err_data_q  <= '0;
         err_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_pos_q   <= sum_pos_d;
         sum_neg_q   <= sum_neg_d;
         err_data_q  <= err_data_d;
         err_valid_q <= err_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign err_data  = err_data_q;
   assign err_valid = err_valid_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adc_sync_demod.sv
// tb_adc_sync_demod
//
// Directed testbench for adc_sync_demod. Drives modulation half-periods with
// a strobe every second cycle and checks the error word, err_valid and
// overrun pulses, busy, and reset/enable behaviour against hand-computed
// values. Expected results follow the ADC_SYNC_DEMOD_AVG_EN setting.

module tb_adc_sync_demod;

   logic        clk;
   logic        rstN;
   logic [11:0] adcData;
   logic        adcReady;
   logic        modPhase;
   logic        demodEn;
   logic [18:0] errData;
   logic        errValid;
   logic        overrun;
   logic        busy;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   int          validSeen;
   int          overrunSeen;
   int          validCycle;
   logic [18:0] lastErr;

`ifdef ADC_SYNC_DEMOD_AVG_EN
   localparam logic [18:0] EXP_900_700 = 19'd512;
   localparam logic [18:0] EXP_FFF_000 = 19'd4095;
   localparam logic [18:0] EXP_000_FFF = 19'h7F001;
`else
   localparam logic [18:0] EXP_900_700 = 19'd32768;
   localparam logic [18:0] EXP_FFF_000 = 19'd262080;
   localparam logic [18:0] EXP_000_FFF = 19'h40040;
`endif

   adc_sync_demod dut (
      .clk_10m_bufg    (clk),
      .rst_glb         (rstN),
      .adc_data_sample (adcData),
      .adc_ready       (adcReady),
      .mod_phase       (modPhase),
      .demod_en        (demodEn),
      .err_data        (errData),
      .err_valid       (errValid),
      .overrun         (overrun),
      .busy            (busy)
   );

   // 10 MHz clock.
   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Compare one observed value against its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Clear the event monitors before a measured section.
   task automatic clearMonitors();
      validSeen   = 0;
      overrunSeen = 0;
      validCycle  = -1;
   endtask

   // Drive one half-period: set the phase, then strobe every odd cycle
   // (optionally also on cycle 2, where the synchronized edge is seen).
   // Samples before cycle 10 carry valEarly, later ones valLate. Outputs
   // are sampled 1 ns after each rising edge.
   task automatic applyStimulus(input logic ph, input int nCyc, input logic [11:0] valEarly,
                                input logic [11:0] valLate, input bit extra);
      modPhase = ph;
      for (int i = 0; i < nCyc; i++) begin
         adcReady = (i % 2 == 1) || (extra && i == 2);
         adcData  = (i < 10) ? valEarly : valLate;
         @(posedge clk);
         #1;
         if (errValid) begin
            validSeen++;
            lastErr    = errData;
            validCycle = i + 1;
         end
         if (overrun) overrunSeen++;
      end
      adcReady = 1'b0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Linear sequence of directed steps.
   initial begin
      rstN     = 1'b0;
      demodEn  = 1'b0;
      modPhase = 1'b0;
      adcReady = 1'b0;
      adcData  = 12'h000;
      lastErr  = '0;
      clearMonitors();

      tick(3);
      checkOutput("reset_err_data", 32'(errData), 32'd0);
      checkOutput("reset_err_valid", 32'(errValid), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);

      rstN = 1'b1;
      tick(2);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      demodEn = 1'b1;
      tick(1);
      checkOutput("enable_busy", 32'(busy), 32'd1);
      tick(3);

      // Constant mid-scale on both halves, two periods.
      $display("[TB] constant 0x800 periods");
      clearMonitors();
      applyStimulus(1'b1, 200, 12'h800, 12'h800, 1'b0);
      applyStimulus(1'b0, 200, 12'h800, 12'h800, 1'b0);
      checkOutput("const_valid_count1", 32'(validSeen), 32'd1);
      checkOutput("const_latency", 32'(validCycle), 32'd139);
      checkOutput("const_err1", 32'(lastErr), 32'd0);
      clearMonitors();
      applyStimulus(1'b1, 200, 12'h800, 12'h800, 1'b0);
      applyStimulus(1'b0, 200, 12'h800, 12'h800, 1'b0);
      checkOutput("const_valid_count2", 32'(validSeen), 32'd1);
      checkOutput("const_err2", 32'(lastErr), 32'd0);
      checkOutput("const_no_overrun", 32'(overrunSeen), 32'd0);

      // Settling samples at full scale must be dropped.
      clearMonitors();
      applyStimulus(1'b1, 200, 12'hFFF, 12'h800, 1'b0);
      applyStimulus(1'b0, 200, 12'hFFF, 12'h800, 1'b0);
      checkOutput("discard_valid", 32'(validSeen), 32'd1);
      checkOutput("discard_err", 32'(lastErr), 32'd0);

      // Extra full-scale strobe on the edge-detect cycle is not counted.
      clearMonitors();
      applyStimulus(1'b1, 200, 12'hFFF, 12'h800, 1'b1);
      applyStimulus(1'b0, 200, 12'h800, 12'h800, 1'b0);
      checkOutput("coincide_valid", 32'(validSeen), 32'd1);
      checkOutput("coincide_err", 32'(lastErr), 32'd0);

      // 0x900 against 0x700.
      clearMonitors();
      applyStimulus(1'b1, 200, 12'h900, 12'h900, 1'b0);
      applyStimulus(1'b0, 200, 12'h700, 12'h700, 1'b0);
      checkOutput("diff_900_700", 32'(lastErr), 32'(EXP_900_700));
      checkOutput("diff_900_700_hold", 32'(errData), 32'(EXP_900_700));

      // Short positive half (about 30 samples) ends in an overrun.
      $display("[TB] early fall edge");
      clearMonitors();
      applyStimulus(1'b1, 70, 12'hFFF, 12'hFFF, 1'b0);
      applyStimulus(1'b0, 200, 12'h000, 12'h000, 1'b0);
      checkOutput("overrun_count", 32'(overrunSeen), 32'd1);
      checkOutput("overrun_no_valid", 32'(validSeen), 32'd0);
      checkOutput("overrun_err_held", 32'(errData), 32'(EXP_900_700));
      clearMonitors();
      applyStimulus(1'b1, 200, 12'hFFF, 12'hFFF, 1'b0);
      applyStimulus(1'b0, 200, 12'h000, 12'h000, 1'b0);
      checkOutput("recover_valid", 32'(validSeen), 32'd1);
      checkOutput("diff_fff_000", 32'(lastErr), 32'(EXP_FFF_000));

      // Full-scale negative difference.
      clearMonitors();
      applyStimulus(1'b1, 200, 12'h000, 12'h000, 1'b0);
      applyStimulus(1'b0, 200, 12'hFFF, 12'hFFF, 1'b0);
      checkOutput("diff_000_fff", 32'(lastErr), 32'(EXP_000_FFF));
      checkOutput("diff_000_fff_no_overrun", 32'(overrunSeen), 32'd0);

      // Drop the enable part-way through the negative accumulation.
      $display("[TB] demod_en abort");
      clearMonitors();
      applyStimulus(1'b1, 200, 12'hFFF, 12'hFFF, 1'b0);
      applyStimulus(1'b0, 60, 12'h000, 12'h000, 1'b0);
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      demodEn = 1'b0;
      applyStimulus(1'b0, 140, 12'h000, 12'h000, 1'b0);
      checkOutput("abort_no_valid", 32'(validSeen), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_err_held", 32'(errData), 32'(EXP_000_FFF));

      // Asynchronous reset in the middle of the positive accumulation.
      demodEn = 1'b1;
      tick(2);
      applyStimulus(1'b1, 60, 12'h900, 12'h900, 1'b0);
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      rstN = 1'b0;
      #10;
      checkOutput("async_reset_err", 32'(errData), 32'd0);
      checkOutput("async_reset_busy", 32'(busy), 32'd0);
      checkOutput("async_reset_valid", 32'(errValid), 32'd0);
      tick(2);
      rstN = 1'b1;
      tick(2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
